// File: rtl/serial_bus_pkg.sv
// rtl/serial_bus_pkg.sv - shared constants, master state encoding and frame length helper for the serial bus
package serial_bus_pkg;

    localparam logic [2:0] START_PATTERN = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_WAIT,
        ST_WDATA,
        ST_GAP,
        ST_RDATA,
        ST_LAST,
        ST_DONE
    } master_state_t;

    // Control frame: start pattern, slave id, write flag, burst flag, address.
    function automatic int frame_len(input int id_w, input int addr_w);
        return 5 + id_w + addr_w;
    endfunction

endpackage

// File: rtl/bit_shifter.sv
// rtl/bit_shifter.sv - word-wide shift register with load, MSB shift-out and LSB shift-in
module bit_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_out,
    input  logic                  shift_in,
    input  logic                  in_bit,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  msb
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    // Load wins over shifting; shift-out backfills zero, shift-in backfills in_bit.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_out) begin
            data_d = {data_q[DATA_WIDTH-2:0], 1'b0};
        end else if (shift_in) begin
            data_d = {data_q[DATA_WIDTH-2:0], in_bit};
        end
    end

    // Shift register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;
    assign msb  = data_q[DATA_WIDTH-1];

endmodule

// File: rtl/master_port.sv
// rtl/master_port.sv - bus master initiator: serializes control frames and write words, deserializes read words
module master_port
    import serial_bus_pkg::*;
#(
    parameter int  ADDR_DEPTH = 2000,
    parameter int  SLAVES     = 3,
    parameter int  DATA_WIDTH = 8,
    parameter int  LEN_W      = 8,
    localparam int ADDR_W     = $clog2(ADDR_DEPTH),
    localparam int ID_W       = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_W-1:0]       cmd_slave,
    input  logic                  cmd_write,
    input  logic                  cmd_burst,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  control,
    output logic                  wD,
    output logic                  valid,
    output logic                  last,
    input  logic                  rD,
    input  logic                  ready
);

    localparam int FRAME_LEN = frame_len(ID_W, ADDR_W);
    localparam int CNT_MAX   = (FRAME_LEN > DATA_WIDTH) ? FRAME_LEN : DATA_WIDTH;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LEN_W-1:0] ONE_WORD   = LEN_W'(1);

    master_state_t          state_q, state_d;
    logic [FRAME_LEN-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]       words_q, words_d;
    logic                   write_q, write_d;
    logic                   burst_q, burst_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    logic                   tx_load;
    logic                   tx_shift;
    logic                   tx_msb;
    logic [DATA_WIDTH-1:0]  tx_data;
    logic                   rx_shift;
    logic [DATA_WIDTH-1:0]  rx_data;
    logic                   rx_msb;
    logic                   unused_shift_bits;

    // Transmit shifter: loaded at a word boundary, drained MSB first onto wD.
    bit_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_tx_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_load),
        .load_data (wr_data),
        .shift_out (tx_shift),
        .shift_in  (1'b0),
        .in_bit    (1'b0),
        .data      (tx_data),
        .msb       (tx_msb)
    );

    // Receive shifter: collects rD into the LSB on every qualified read bit.
    bit_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_rx_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ({DATA_WIDTH{1'b0}}),
        .shift_out (1'b0),
        .shift_in  (rx_shift),
        .in_bit    (rD),
        .data      (rx_data),
        .msb       (rx_msb)
    );

    // Only the transmit MSB and the low receive bits feed the datapath.
    assign unused_shift_bits = ^{tx_data, rx_data[DATA_WIDTH-1], rx_msb};

    // Next-state and bus outputs; every serial line idles low outside its own state.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        words_d    = words_q;
        write_d    = write_q;
        burst_d    = burst_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;
        cmd_ready  = 1'b0;
        control    = 1'b0;
        wD         = 1'b0;
        valid      = 1'b0;
        last       = 1'b0;
        wr_ready   = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    frame_d   = {START_PATTERN, cmd_slave, cmd_write, cmd_burst, cmd_addr};
                    write_d   = cmd_write;
                    burst_d   = cmd_burst;
                    words_d   = !cmd_burst ? ONE_WORD :
                                (cmd_len == '0) ? ONE_WORD : cmd_len;
                    bit_cnt_d = '0;
                    state_d   = ST_CTRL;
                end
            end
            ST_CTRL: begin
                control = frame_q[FRAME_LEN-1];
                frame_d = frame_q << 1;
                if (bit_cnt_q == FRAME_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = ST_WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT, ST_GAP: begin
                // Reads have no handshake at the boundary; writes wait for slave and source.
                if (!write_q) begin
                    state_d = ST_RDATA;
                end else if (ready && wr_valid) begin
                    tx_load   = 1'b1;
                    wr_ready  = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ST_WDATA;
                end
            end
            ST_WDATA: begin
                valid    = 1'b1;
                wD       = tx_msb;
                last     = burst_q && (words_q == ONE_WORD);
                tx_shift = 1'b1;
                if (bit_cnt_q == WORD_LAST) begin
                    bit_cnt_d = '0;
                    words_d   = words_q - ONE_WORD;
                    state_d   = (words_q == ONE_WORD) ? ST_DONE : ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            ST_RDATA: begin
                if (ready) begin
                    rx_shift = 1'b1;
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d  = '0;
                        rd_data_d  = {rx_data[DATA_WIDTH-2:0], rD};
                        rd_valid_d = 1'b1;
                        words_d    = words_q - ONE_WORD;
                        if (words_q == ONE_WORD) begin
                            state_d = burst_q ? ST_LAST : ST_DONE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LAST: begin
                last    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command latch and read-word registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            words_q    <= '0;
            write_q    <= 1'b0;
            burst_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            words_q    <= words_d;
            write_q    <= write_d;
            burst_q    <= burst_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - self-checking bench for master_port against a transaction-level bus model
module tb_master_port;

    localparam int DW     = 8;
    localparam int ID_W   = 2;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 8;
    localparam int F      = 18;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ID_W-1:0]   cmd_slave;
    logic              cmd_write;
    logic              cmd_burst;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              done;
    logic              control;
    logic              wD;
    logic              valid;
    logic              last;
    logic              rD;
    logic              ready;

    int checks;
    int failures;
    logic [DW-1:0] txn_data[$];

    always #5 clk = ~clk;

    master_port #(
        .ADDR_DEPTH (2000),
        .SLAVES     (3),
        .DATA_WIDTH (DW),
        .LEN_W      (LEN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_slave (cmd_slave),
        .cmd_write (cmd_write),
        .cmd_burst (cmd_burst),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .control   (control),
        .wD        (wD),
        .valid     (valid),
        .last      (last),
        .rD        (rD),
        .ready     (ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command from acceptance to done; the slave side follows the protocol timing:
    // frame on cycles 1..F, write boundary from F+1, read bits from F+2.
    task automatic run_txn(input string tag, input int slave, input bit wr, input bit bst,
                           input int addr, input int len, input int pct, input int hold_off,
                           input bit junk);
        int n_words, c, widx, ridx, rbit;
        int ctrl_bad, wd_bad, timing_bad, runs_bad, run_len, cur_last;
        int wr_pulses, valid_cycles, last_cycles, last_cycle, done_cycle, first_valid;
        bit prev_valid, prev_wr_ready, finished;
        logic [F-1:0]  exp_frame, got_frame;
        logic [DW-1:0] cur_word, src;
        logic [DW-1:0] got_words[$];
        logic [DW-1:0] rd_words[$];
        int lasts[$];

        n_words   = bst ? ((len == 0) ? 1 : len) : 1;
        exp_frame = {3'b111, ID_W'(slave), wr, bst, ADDR_W'(addr)};
        got_frame = '0;
        c = 0; widx = 0; ridx = 0; rbit = 0;
        ctrl_bad = 0; wd_bad = 0; timing_bad = 0; runs_bad = 0; run_len = 0; cur_last = 0;
        wr_pulses = 0; valid_cycles = 0; last_cycles = 0; last_cycle = -1; done_cycle = -1;
        first_valid = -1; prev_valid = 0; prev_wr_ready = 0; finished = 0;
        cur_word = '0;

        while (!finished && c < 3000) begin
            @(negedge clk);
            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_slave = ID_W'(slave);
                cmd_write = wr;
                cmd_burst = bst;
                cmd_addr  = ADDR_W'(addr);
                cmd_len   = LEN_W'(len);
            end else begin
                cmd_valid = junk && ($urandom_range(0, 1) == 1);
                cmd_slave = ID_W'($urandom_range(0, 2));
                cmd_write = ~wr;
                cmd_burst = ($urandom_range(0, 1) == 1);
                cmd_addr  = ADDR_W'($urandom_range(0, 2047));
                cmd_len   = LEN_W'($urandom_range(0, 255));
            end
            if (wr) begin
                if (c >= F + 1 && c < F + 1 + hold_off) ready = 1'b0;
                else ready = ($urandom_range(0, 99) < pct);
                wr_valid = ($urandom_range(0, 99) < pct);
                wr_data  = (widx < n_words) ? txn_data[widx] : DW'($urandom);
                rD       = ($urandom_range(0, 1) == 1);
            end else begin
                wr_valid = ($urandom_range(0, 1) == 1);
                wr_data  = DW'($urandom);
                if (c >= F + 2 && ridx < n_words) begin
                    if ($urandom_range(0, 99) < pct) begin
                        ready = 1'b1;
                        src   = txn_data[ridx];
                        rD    = src[DW-1-rbit];
                        rbit++;
                        if (rbit == DW) begin
                            rbit = 0;
                            ridx++;
                        end
                    end else begin
                        ready = 1'b0;
                        rD    = ($urandom_range(0, 1) == 1);
                    end
                end else begin
                    ready = ($urandom_range(0, 1) == 1);
                    rD    = ($urandom_range(0, 1) == 1);
                end
            end
            #1;
            if (c == 0) check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
            if (c >= 1 && c <= F) got_frame = {got_frame[F-2:0], control};
            else if (control !== 1'b0) ctrl_bad++;
            if (wr_ready === 1'b1) begin
                wr_pulses++;
                widx++;
            end
            if (valid === 1'b1) begin
                valid_cycles++;
                if (!prev_valid && !prev_wr_ready) timing_bad++;
                if (first_valid < 0) first_valid = c;
                cur_word = {cur_word[DW-2:0], wD};
                run_len++;
                if (last === 1'b1) cur_last++;
            end else begin
                if (wD !== 1'b0) wd_bad++;
                if (prev_valid) begin
                    if (run_len != DW) runs_bad++;
                    got_words.push_back(cur_word);
                    lasts.push_back(cur_last);
                    run_len  = 0;
                    cur_last = 0;
                end
                if (last === 1'b1) begin
                    last_cycles++;
                    last_cycle = c;
                end
            end
            if (rd_valid === 1'b1) rd_words.push_back(rd_data);
            if (done === 1'b1) begin
                finished   = 1;
                done_cycle = c;
            end
            prev_valid    = (valid === 1'b1);
            prev_wr_ready = (wr_ready === 1'b1);
            c++;
        end

        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_frame"}, 32'(got_frame), 32'(exp_frame));
        check({tag, "_control_idle"}, ctrl_bad, 0);
        check({tag, "_wd_idle"}, wd_bad, 0);
        if (wr) begin
            check({tag, "_wr_ready_pulses"}, wr_pulses, n_words);
            check({tag, "_words_seen"}, got_words.size(), n_words);
            check({tag, "_word_len_gap"}, runs_bad, 0);
            check({tag, "_valid_after_wr_ready"}, timing_bad, 0);
            check({tag, "_last_outside_words"}, last_cycles, 0);
            check({tag, "_no_rd_valid"}, rd_words.size(), 0);
            for (int i = 0; i < got_words.size() && i < n_words; i++) begin
                check($sformatf("%s_wdata%0d", tag, i), 32'(got_words[i]), 32'(txn_data[i]));
                check($sformatf("%s_last%0d", tag, i), lasts[i],
                      (bst && i == n_words - 1) ? DW : 0);
            end
            if (pct == 100) check({tag, "_first_valid"}, first_valid, F + 2 + hold_off);
        end else begin
            check({tag, "_no_valid"}, valid_cycles, 0);
            check({tag, "_no_wr_ready"}, wr_pulses, 0);
            check({tag, "_rd_count"}, rd_words.size(), n_words);
            for (int i = 0; i < rd_words.size() && i < n_words; i++) begin
                check($sformatf("%s_rdata%0d", tag, i), 32'(rd_words[i]), 32'(txn_data[i]));
            end
            check({tag, "_last_cycles"}, last_cycles, bst ? 1 : 0);
            if (bst) check({tag, "_last_before_done"}, last_cycle, done_cycle - 1);
        end

        @(negedge clk);
        cmd_valid = 1'b0;
        ready     = 1'b0;
        wr_valid  = 1'b0;
        #1;
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_slave = '0;
        cmd_write = 1'b0;
        cmd_burst = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_data   = '0;
        wr_valid  = 1'b0;
        rD        = 1'b0;
        ready     = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({control, wD, valid, last, wr_ready, rd_valid, done}), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;

        // Single write, slave 1, addr 0, 8'hA5
        txn_data = '{8'hA5};
        run_txn("single_write", 1, 1'b1, 1'b0, 0, 0, 100, 0, 1'b0);

        // Burst write, slave 1, addr 3, three words
        txn_data = '{8'h01, 8'h02, 8'h03};
        run_txn("burst_write", 1, 1'b1, 1'b1, 3, 3, 100, 0, 1'b1);

        // Burst read with ready gaps
        txn_data = '{8'h3C, 8'hC3};
        run_txn("burst_read", 1, 1'b0, 1'b1, 3, 2, 60, 0, 1'b1);

        // Write stalled by ready low for ten cycles after the frame
        txn_data = '{8'h5A};
        run_txn("write_stall", 0, 1'b1, 1'b0, 100, 0, 100, 10, 1'b0);

        // Single read, slave 2, top address
        txn_data = '{8'hFF};
        run_txn("single_read", 2, 1'b0, 1'b0, 2047, 0, 100, 0, 1'b1);

        // Burst with zero length behaves as a single word that carries last
        txn_data = '{8'h96};
        run_txn("burst_len0", 2, 1'b1, 1'b1, 77, 0, 100, 0, 1'b0);

        // Reset during word 2 of a burst write
        begin
            int c, pulses, vbits, d, v;
            txn_data = '{8'h11, 8'h22, 8'h33};
            c = 0; pulses = 0; vbits = 0;
            while (vbits < 3 && c < 200) begin
                @(negedge clk);
                cmd_valid = (c == 0);
                cmd_slave = 2'd1;
                cmd_write = 1'b1;
                cmd_burst = 1'b1;
                cmd_addr  = 11'd3;
                cmd_len   = 8'd3;
                ready     = 1'b1;
                wr_valid  = 1'b1;
                wr_data   = txn_data[(pulses < 3) ? pulses : 0];
                #1;
                if (wr_ready === 1'b1) pulses++;
                if (pulses == 2 && valid === 1'b1) vbits++;
                c++;
            end
            check("rst_reached_word2", vbits, 3);
            #1;
            reset = 1'b1;
            #1;
            check("rst_outputs", 32'({control, wD, valid, last, wr_ready, rd_valid, done}), 32'd0);
            check("rst_rd_data", 32'(rd_data), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            reset     = 1'b0;
            cmd_valid = 1'b0;
            d = 0;
            v = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                #1;
                if (done === 1'b1) d++;
                if (valid === 1'b1) v++;
            end
            check("rst_no_done", d, 0);
            check("rst_no_valid", v, 0);
            check("rst_idle_after", 32'(cmd_ready), 32'd1);
        end

        // Randomized transactions
        for (int t = 0; t < 8; t++) begin
            int s, a, l, p, n;
            bit w, b;
            s = $urandom_range(0, 2);
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 2047);
            l = $urandom_range(0, 4);
            p = $urandom_range(50, 100);
            n = (b && l > 0) ? l : 1;
            txn_data.delete();
            for (int i = 0; i < n; i++) txn_data.push_back(DW'($urandom));
            run_txn($sformatf("rand%0d", t), s, w, b, a, l, p, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
